// File: rtl/video_vfilter.sv
// video_vfilter: vertical 2-tap blend of mono video with the previous line,
// pixel and sync/blank strobes kept aligned through a 2-stage pipeline.
module video_vfilter #(
  parameter int MAX_W = 640,
  parameter int AW    = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce_pix,
  input  logic [1:0] mode,
  input  logic       hblank_in,
  input  logic       hsync_in,
  input  logic       vblank_in,
  input  logic       vsync_in,
  input  logic [7:0] video_in,
  output logic       hblank_o,
  output logic       hsync_o,
  output logic       vblank_o,
  output logic       vsync_o,
  output logic [7:0] video_o
);
  localparam logic [AW-1:0] W_LIM = AW'(MAX_W);
  logic [7:0]    r_mem [0:(1<<AW)-1];
  logic [7:0]    r_rd, r_v1;
  logic [AW-1:0] r_col, r_col1;
  logic          r_hb1, r_hs1, r_vb1, r_vs1, r_line_ok;
  logic [1:0]    r_mode;
  logic [9:0]    w_cur, w_prev;
  logic [7:0]    w_avg, w_wt, w_pix;
  logic          w_byp;
  // read-before-write line buffer; contents only matter once line_ok is set
  always_ff @(posedge clk)
    if (ce_pix) begin
      r_rd <= r_mem[r_col];
      if (!hblank_in && !vblank_in && r_col < W_LIM) r_mem[r_col] <= video_in;
    end
  assign w_cur  = {2'b0, r_v1};
  assign w_prev = {2'b0, r_rd};
  assign w_avg  = 8'((w_cur + w_prev + 10'd1) >> 1);
  assign w_wt   = 8'((10'd3 * w_cur + w_prev + 10'd2) >> 2);
  assign w_byp  = r_mode == 2'd0 || r_mode == 2'd3 || !r_line_ok || r_col1 >= W_LIM;
  assign w_pix  = w_byp ? r_v1 : (r_mode == 2'd1 ? w_avg : w_wt);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_col     <= '0;
      r_col1    <= '0;
      r_v1      <= '0;
      r_hb1     <= 1'b0;
      r_hs1     <= 1'b0;
      r_vb1     <= 1'b0;
      r_vs1     <= 1'b0;
      r_line_ok <= 1'b0;
      r_mode    <= 2'd0;
      hblank_o  <= 1'b0;
      hsync_o   <= 1'b0;
      vblank_o  <= 1'b0;
      vsync_o   <= 1'b0;
      video_o   <= '0;
    end else if (ce_pix) begin
      r_col     <= hblank_in ? '0 : (r_col >= W_LIM ? r_col : r_col + 1'b1);
      r_col1    <= r_col;
      r_v1      <= video_in;
      r_hb1     <= hblank_in;
      r_hs1     <= hsync_in;
      r_vb1     <= vblank_in;
      r_vs1     <= vsync_in;
      r_mode    <= (vsync_in && !r_vs1) ? mode : r_mode;
      r_line_ok <= vblank_in ? 1'b0 : ((hblank_in && !r_hb1 && r_col != '0) ? 1'b1 : r_line_ok);
      hblank_o  <= r_hb1;
      hsync_o   <= r_hs1;
      vblank_o  <= r_vb1;
      vsync_o   <= r_vs1;
      video_o   <= (r_hb1 || r_vb1) ? 8'd0 : w_pix;
    end
endmodule

// File: tb/tb_video_vfilter.sv
// tb_video_vfilter: directed vectors for the vertical filter, run with an
// 8-pixel line buffer so overlong lines are easy to build.
module tb_video_vfilter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ce_pix = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       hblank_in = 1'b0, hsync_in = 1'b0, vblank_in = 1'b0, vsync_in = 1'b0;
  logic [7:0] video_in = 8'd0;
  logic       hblank_o, hsync_o, vblank_o, vsync_o;
  logic [7:0] video_o;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [1:0] m;
    logic       hb, hs, vb, vs;
    logic [7:0] v, e;
    logic       half;
  } rec_t;
  rec_t tbl[$];

  video_vfilter #(.MAX_W(8), .AW(4)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .mode(mode),
    .hblank_in(hblank_in), .hsync_in(hsync_in), .vblank_in(vblank_in), .vsync_in(vsync_in),
    .video_in(video_in),
    .hblank_o(hblank_o), .hsync_o(hsync_o), .vblank_o(vblank_o), .vsync_o(vsync_o),
    .video_o(video_o)
  );

  always #5 clk = ~clk;

  task automatic px(input logic [1:0] m, input logic [7:0] v, input logic [7:0] e, input logic h);
    tbl.push_back('{m, 1'b0, 1'b0, 1'b0, 1'b0, v, e, h});
  endtask

  task automatic hbl(input logic [1:0] m);
    for (int k = 0; k < 3; k++) tbl.push_back('{m, 1'b1, k == 1, 1'b0, 1'b0, 8'hA5, 8'd0, 1'b0});
  endtask

  task automatic vbl(input logic [1:0] m);
    for (int k = 0; k < 4; k++) tbl.push_back('{m, 1'b1, 1'b0, 1'b1, k < 2, 8'h5A, 8'd0, 1'b0});
  endtask

  task automatic check(input rec_t r, input int idx);
    total += 2;
    if (video_o !== r.e) begin
      bad++;
      $display("FAIL video[%0d]: got %0d want %0d", idx, video_o, r.e);
    end
    if ({hblank_o, hsync_o, vblank_o, vsync_o} !== {r.hb, r.hs, r.vb, r.vs}) begin
      bad++;
      $display("FAIL strobes[%0d]: got %b want %b", idx,
               {hblank_o, hsync_o, vblank_o, vsync_o}, {r.hb, r.hs, r.vb, r.vs});
    end
  endtask

  task automatic hold_check(input int idx);
    logic [11:0] snap;
    snap = {hblank_o, hsync_o, vblank_o, vsync_o, video_o};
    ce_pix = 1'b0;
    {hblank_in, hsync_in, vblank_in, vsync_in} = 4'($urandom);
    video_in = 8'($urandom);
    mode = 2'($urandom);
    @(posedge clk); #1;
    total++;
    if ({hblank_o, hsync_o, vblank_o, vsync_o, video_o} !== snap) begin
      bad++;
      $display("FAIL hold[%0d]: got %h want %h", idx,
               {hblank_o, hsync_o, vblank_o, vsync_o, video_o}, snap);
    end
  endtask

  // Output after edge i reflects the record driven into edge i-1.
  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      mode = tbl[i].m;
      hblank_in = tbl[i].hb;
      hsync_in = tbl[i].hs;
      vblank_in = tbl[i].vb;
      vsync_in = tbl[i].vs;
      video_in = tbl[i].v;
      ce_pix = 1'b1;
      @(posedge clk); #1;
      if (i > lo) check(tbl[i-1], i - 1);
      if (tbl[i].half) hold_check(i);
    end
  endtask

  task automatic zero_check(input string nm);
    total++;
    if ({hblank_o, hsync_o, vblank_o, vsync_o, video_o} !== 12'd0) begin
      bad++;
      $display("FAIL %s: got %h want 000", nm, {hblank_o, hsync_o, vblank_o, vsync_o, video_o});
    end
  endtask

  initial begin
    int n1;
    int ramp_b[8];
    ramp_b = '{100, 105, 110, 115, 120, 125, 130, 135};
    // frame 1: average; line C requests mode 2 mid-frame which must be ignored
    vbl(2'd1);
    for (int k = 0; k < 4; k++) px(2'd1, 8'd100, 8'd100, 1'b0);
    hbl(2'd1);
    for (int k = 0; k < 4; k++) px(2'd1, 8'd201, 8'd151, 1'b0);
    hbl(2'd1);
    for (int k = 0; k < 4; k++) px(2'd2, 8'd0, 8'd101, 1'b0);
    hbl(2'd2);
    // frame 2: weighted extremes
    vbl(2'd2);
    px(2'd2, 8'd0, 8'd0, 1'b0);
    px(2'd2, 8'd255, 8'd255, 1'b0);
    px(2'd2, 8'd255, 8'd255, 1'b0);
    px(2'd2, 8'd0, 8'd0, 1'b0);
    hbl(2'd2);
    px(2'd2, 8'd255, 8'd191, 1'b0);
    px(2'd2, 8'd0, 8'd64, 1'b0);
    px(2'd2, 8'd255, 8'd255, 1'b0);
    px(2'd2, 8'd0, 8'd0, 1'b0);
    hbl(2'd2);
    // frame 3: 12-pixel lines against 8-deep buffer, second line at half ce duty
    vbl(2'd1);
    for (int k = 0; k < 12; k++) px(2'd1, 8'(k * 10), 8'(k * 10), 1'b0);
    hbl(2'd1);
    for (int k = 0; k < 12; k++) px(2'd1, 8'd200, k < 8 ? 8'(ramp_b[k]) : 8'd200, 1'b1);
    hbl(2'd1);
    // frame 4: mode 3 behaves as bypass
    vbl(2'd3);
    for (int k = 0; k < 4; k++) px(2'd3, 8'd40, 8'd40, 1'b0);
    hbl(2'd3);
    for (int k = 0; k < 4; k++) px(2'd3, 8'd80, 8'd80, 1'b0);
    hbl(2'd3);
    // frame 5: bypass ramp, ends mid-line for the reset test
    vbl(2'd0);
    for (int k = 0; k < 6; k++) px(2'd0, 8'(k), 8'(k), 1'b0);
    hbl(2'd0);
    for (int k = 0; k < 6; k++) px(2'd0, 8'(10 + k), 8'(10 + k), 1'b0);
    hbl(2'd0);
    px(2'd0, 8'd7, 8'd7, 1'b0);
    px(2'd0, 8'd9, 8'd9, 1'b0);
    px(2'd0, 8'd11, 8'd11, 1'b0);
    n1 = tbl.size();
    // after reset: vsync without vblank latches mode 1; first line still unfiltered
    tbl.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 8'd0, 1'b0});
    tbl.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 8'd0, 1'b0});
    tbl.push_back('{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h33, 8'd0, 1'b0});
    for (int k = 0; k < 4; k++) px(2'd1, 8'd50, 8'd50, 1'b0);
    hbl(2'd1);
    for (int k = 0; k < 4; k++) px(2'd1, 8'd150, 8'd100, 1'b0);
    hbl(2'd1);

    repeat (2) @(posedge clk);
    #1 zero_check("reset_state");
    reset = 1'b0;
    run(0, n1);
    #1 reset = 1'b1;
    #1 zero_check("async_reset");
    @(posedge clk); #1;
    zero_check("reset_held");
    reset = 1'b0;
    run(n1, tbl.size());
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
